// File: rtl/car_sensor_cond_if.sv
// Purpose: detector-side bundle between the raw vehicle detector and traffic_light.
// Latency: none; plain wires.
// Backpressure: none; levels and pulses only, no handshake.
//
// Signals:
//   sensor_raw  raw detector level, asynchronous, 1 = vehicle
//   clr_count   synchronous pulse that clears car_count
//   c           conditioned car-present request
//   fault       detector judged stuck-on; c is forced 0 while set
//   car_count   saturating arrival count
// Modports: master drives sensor_raw/clr_count (stimulus side), slave is the conditioner.
interface car_sensor_cond_if #(
    parameter int CNT_W = 8
);
    logic             sensor_raw;
    logic             clr_count;
    logic             c;
    logic             fault;
    logic [CNT_W-1:0] car_count;

    modport master (
        output sensor_raw,
        output clr_count,
        input  c,
        input  fault,
        input  car_count
    );

    modport slave (
        input  sensor_raw,
        input  clr_count,
        output c,
        output fault,
        output car_count
    );
endinterface

// File: rtl/car_sensor_cond.sv
// Purpose: turn the bouncy asynchronous farm-road detector into a clean car-present request.
// Latency: rise at most 2 + DEB_TICKS*TICK_DIV + TICK_DIV + 1 cycles; c stays up HOLD_TICKS ticks after the fall.
// Backpressure: none; the outputs are registered levels recomputed every cycle.
//
// Ports:
//   clk_125M  system clock
//   rst       asynchronous reset, active-low
//   bus       car_sensor_cond_if.slave: sensor_raw/clr_count in, c/fault/car_count out
module car_sensor_cond #(
    parameter int TICK_DIV    = 125000,
    parameter int DEB_TICKS   = 20,
    parameter int HOLD_TICKS  = 2000,
    parameter int STUCK_TICKS = 300000,
    parameter int CNT_W       = 8
) (
    input  logic                 clk_125M,
    input  logic                 rst,
    car_sensor_cond_if.slave     bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int SW = $clog2(STUCK_TICKS + 1);

    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0]    DEB_LAST   = DW'(DEB_TICKS - 1);
    localparam logic [HW-1:0]    HOLD_INIT  = HW'(HOLD_TICKS);
    localparam logic [HW-1:0]    HOLD_ONE   = HW'(1);
    localparam logic [SW-1:0]    STUCK_LAST = SW'(STUCK_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        HOLD    = 2'd2,
        STUCK   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous detector level
    // ------------------------------------------------------------------
    logic s_meta;
    logic s;

    always_ff @(posedge clk_125M or negedge rst) begin
        if (!rst) begin
            s_meta <= 1'b0;
            s      <= 1'b0;
        end else begin
            s_meta <= bus.sensor_raw;
            s      <= s_meta;
        end
    end

    // ------------------------------------------------------------------
    // Sample-tick prescaler: tick is high for the single cycle at TICK_DIV-1
    // ------------------------------------------------------------------
    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk_125M or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Debounce: deb flips only after DEB_TICKS consecutive differing ticks
    // ------------------------------------------------------------------
    logic          deb;
    logic [DW-1:0] deb_cnt;

    always_ff @(posedge clk_125M or negedge rst) begin
        if (!rst) begin
            deb     <= 1'b0;
            deb_cnt <= '0;
        end else if (tick) begin
            if (s != deb) begin
                if (deb_cnt == DEB_LAST) begin
                    deb     <= ~deb;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Presence FSM
    // ------------------------------------------------------------------
    state_t        state;
    state_t        state_nxt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;
    logic [SW-1:0] stuck_cnt;
    logic [SW-1:0] stuck_nxt;
    logic          arrival;
    logic          c_q;
    logic          c_nxt;
    logic          fault_q;
    logic          fault_nxt;

    // State register; c/fault are registered decodes of the next state so
    // they move on the same edge as the state itself.
    always_ff @(posedge clk_125M or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            stuck_cnt <= '0;
            c_q       <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            stuck_cnt <= stuck_nxt;
            c_q       <= c_nxt;
            fault_q   <= fault_nxt;
        end
    end

    // Next-state logic. A falling deb in PRESENT takes priority over the tick,
    // so the stuck timer never advances on the cycle we leave for HOLD. A
    // returning deb in HOLD takes priority over the hold timer expiring.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        stuck_nxt = stuck_cnt;
        arrival   = 1'b0;
        case (state)
            IDLE: begin
                if (deb) begin
                    state_nxt = PRESENT;
                    stuck_nxt = '0;
                    arrival   = 1'b1;
                end
            end
            PRESENT: begin
                if (!deb) begin
                    state_nxt = HOLD;
                    hold_nxt  = HOLD_INIT;
                end else if (tick) begin
                    stuck_nxt = stuck_cnt + SW'(1);
                    if (stuck_cnt == STUCK_LAST) begin
                        state_nxt = STUCK;
                    end
                end
            end
            HOLD: begin
                if (deb) begin
                    // Same vehicle re-detected inside the gap: no new arrival.
                    state_nxt = PRESENT;
                    stuck_nxt = '0;
                end else if (tick) begin
                    hold_nxt = hold_cnt - HW'(1);
                    if (hold_cnt <= HOLD_ONE) begin
                        state_nxt = IDLE;
                    end
                end
            end
            STUCK: begin
                if (!deb) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode of the upcoming state.
    always_comb begin
        c_nxt     = 1'b0;
        fault_nxt = 1'b0;
        case (state_nxt)
            PRESENT: c_nxt     = 1'b1;
            HOLD:    c_nxt     = 1'b1;
            STUCK:   fault_nxt = 1'b1;
            default: begin
                c_nxt     = 1'b0;
                fault_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Arrival counter: clear wins over hold, but a coinciding arrival still lands
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] car_cnt;

    always_ff @(posedge clk_125M or negedge rst) begin
        if (!rst) begin
            car_cnt <= '0;
        end else if (bus.clr_count) begin
            car_cnt <= arrival ? CNT_W'(1) : '0;
        end else if (arrival && (car_cnt != CNT_MAX)) begin
            car_cnt <= car_cnt + CNT_W'(1);
        end
    end

    assign bus.c         = c_q;
    assign bus.fault     = fault_q;
    assign bus.car_count = car_cnt;

endmodule

// File: tb/tb_car_sensor_cond.sv
// Purpose: self-checking bench for car_sensor_cond with small timing parameters.
// Latency: outputs sampled 1 ns after each rising edge against a behavioural model.
// Backpressure: not applicable.
module tb_car_sensor_cond;

    localparam int TD = 4;
    localparam int DT = 3;
    localparam int HT = 5;
    localparam int ST = 20;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_PRES  = 1;
    localparam int M_HOLD  = 2;
    localparam int M_STUCK = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    car_sensor_cond_if #(.CNT_W(CW)) bus ();

    car_sensor_cond #(
        .TICK_DIV    (TD),
        .DEB_TICKS   (DT),
        .HOLD_TICKS  (HT),
        .STUCK_TICKS (ST),
        .CNT_W       (CW)
    ) dut (
        .clk_125M (clk),
        .rst      (rst_n),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- behavioural reference ----------------
    int m_q[$];      // raw samples in flight through the synchroniser, oldest first
    int m_cyc;       // clock edges since reset release
    int m_deb;
    int m_run;       // consecutive ticks on which the synchronised level disagreed
    int m_mode;
    int m_hold;
    int m_stuck;
    int m_count;

    function automatic void model_reset();
        m_q     = '{0, 0};
        m_cyc   = 0;
        m_deb   = 0;
        m_run   = 0;
        m_mode  = M_IDLE;
        m_hold  = 0;
        m_stuck = 0;
        m_count = 0;
    endfunction

    function automatic void model_edge(input int raw, input int clr);
        int is_tick;
        int s_now;
        int arrive;
        int nm;
        is_tick = ((m_cyc % TD) == TD - 1) ? 1 : 0;
        s_now   = m_q[0];
        arrive  = (m_mode == M_IDLE && m_deb == 1) ? 1 : 0;
        nm      = m_mode;
        if (m_mode == M_IDLE) begin
            if (m_deb == 1) begin
                nm = M_PRES;
                m_stuck = 0;
            end
        end else if (m_mode == M_PRES) begin
            if (m_deb == 0) begin
                nm = M_HOLD;
                m_hold = HT;
            end else if (is_tick == 1) begin
                m_stuck = m_stuck + 1;
                if (m_stuck >= ST) nm = M_STUCK;
            end
        end else if (m_mode == M_HOLD) begin
            if (m_deb == 1) begin
                nm = M_PRES;
                m_stuck = 0;
            end else if (is_tick == 1) begin
                m_hold = m_hold - 1;
                if (m_hold <= 0) nm = M_IDLE;
            end
        end else begin
            if (m_deb == 0) nm = M_IDLE;
        end
        m_mode = nm;

        if (clr == 1) m_count = arrive;
        else if (arrive == 1 && m_count < CMAX) m_count = m_count + 1;

        if (is_tick == 1) begin
            if (s_now != m_deb) begin
                m_run = m_run + 1;
                if (m_run == DT) begin
                    m_deb = 1 - m_deb;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end

        void'(m_q.pop_front());
        m_q.push_back(raw);
        m_cyc = m_cyc + 1;
    endfunction

    function automatic logic [31:0] exp_c();
        return (m_mode == M_PRES || m_mode == M_HOLD) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] exp_fault();
        return (m_mode == M_STUCK) ? 32'd1 : 32'd0;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n === 1'b1) model_edge(int'(bus.sensor_raw), int'(bus.clr_count));
        else model_reset();
        #1;
        check("c", 32'(bus.c), exp_c());
        check("fault", 32'(bus.fault), exp_fault());
        check("car_count", 32'(bus.car_count), 32'(m_count));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_c(input logic val, input int budget, output int n);
        n = 0;
        while (bus.c !== val && n < budget) begin
            cyc();
            n++;
        end
        check("wait_c", 32'(bus.c), 32'(val));
    endtask

    task automatic wait_fault(input logic val, input int budget, output int n);
        n = 0;
        while (bus.fault !== val && n < budget) begin
            cyc();
            n++;
        end
        check("wait_fault", 32'(bus.fault), 32'(val));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int n;
        int seen;
        int cnt_before;

        bus.sensor_raw = 1'b0;
        bus.clr_count  = 1'b0;
        model_reset();

        // Reset held: raw toggling must not disturb the outputs.
        for (int i = 0; i < 8; i++) begin
            bus.sensor_raw = i[0];
            cyc();
        end
        check("rst_c", 32'(bus.c), 32'd0);
        check("rst_count", 32'(bus.car_count), 32'd0);

        // Release with raw already high: ticks at edges 4, 8, 12 flip deb, c rises at edge 13.
        bus.sensor_raw = 1'b1;
        rst_n = 1'b1;
        wait_c(1'b1, 40, n);
        check("rise_latency", 32'(n), 32'd13);
        check("count_first", 32'(bus.car_count), 32'd1);
        run(40 - n);

        // Fall: synchroniser 2-3 edges, three zero ticks, then five hold ticks.
        bus.sensor_raw = 1'b0;
        wait_c(1'b0, 60, n);
        check("fall_latency", 32'(n), 32'd32);
        run(10);

        // Glitch of 6 cycles never spans three ticks.
        seen = 0;
        bus.sensor_raw = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (bus.c === 1'b1) seen = 1;
        end
        bus.sensor_raw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (bus.c === 1'b1) seen = 1;
        end
        check("glitch_no_c", 32'(seen), 32'd0);
        check("glitch_count", 32'(bus.car_count), 32'd1);

        // Gap bridge: 16-cycle dropout is covered by the hold window.
        bus.sensor_raw = 1'b1;
        wait_c(1'b1, 40, n);
        run(20);
        seen = 0;
        bus.sensor_raw = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (bus.c !== 1'b1) seen = 1;
        end
        bus.sensor_raw = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (bus.c !== 1'b1) seen = 1;
        end
        check("gap_c_held", 32'(seen), 32'd0);
        check("gap_count", 32'(bus.car_count), 32'd2);
        bus.sensor_raw = 1'b0;
        wait_c(1'b0, 80, n);
        run(10);

        // Stuck detector: 20 ticks of presence forces c low and raises fault.
        bus.sensor_raw = 1'b1;
        wait_c(1'b1, 40, n);
        wait_fault(1'b1, 200, n);
        check("stuck_c_low", 32'(bus.c), 32'd0);
        check("stuck_count", 32'(bus.car_count), 32'd3);
        bus.sensor_raw = 1'b0;
        wait_fault(1'b0, 40, n);
        check("unstuck_c", 32'(bus.c), 32'd0);
        check("unstuck_count", 32'(bus.car_count), 32'd3);
        run(5);
        bus.sensor_raw = 1'b1;
        wait_c(1'b1, 40, n);
        check("after_stuck_count", 32'(bus.car_count), 32'd4);
        bus.sensor_raw = 1'b0;
        wait_c(1'b0, 80, n);

        // Saturation: 260 clean arrivals on top of 4.
        for (int k = 0; k < 260; k++) begin
            bus.sensor_raw = 1'b1;
            run(24);
            bus.sensor_raw = 1'b0;
            run(44);
        end
        check("saturated", 32'(bus.car_count), 32'(CMAX));

        bus.clr_count = 1'b1;
        cyc();
        bus.clr_count = 1'b0;
        check("clr_zero", 32'(bus.car_count), 32'd0);

        for (int k = 0; k < 2; k++) begin
            bus.sensor_raw = 1'b1;
            run(24);
            bus.sensor_raw = 1'b0;
            run(44);
        end
        check("recount", 32'(bus.car_count), 32'd2);

        // Clear coinciding with an arrival edge.
        bus.sensor_raw = 1'b1;
        n = 0;
        while (!(m_mode == M_IDLE && m_deb == 1) && n < 40) begin
            cyc();
            n++;
        end
        check("arrival_pending", 32'(m_mode == M_IDLE && m_deb == 1), 32'd1);
        bus.clr_count = 1'b1;
        cyc();
        bus.clr_count = 1'b0;
        check("clr_with_arrival", 32'(bus.car_count), 32'd1);
        bus.sensor_raw = 1'b0;
        wait_c(1'b0, 80, n);

        // Random pulse trains with sporadic clears.
        for (int k = 0; k < 40; k++) begin
            bus.sensor_raw = 1'b1;
            for (int i = 0; i < int'($urandom_range(1, 40)); i++) begin
                bus.clr_count = ($urandom_range(0, 15) == 0);
                cyc();
            end
            bus.sensor_raw = 1'b0;
            for (int i = 0; i < int'($urandom_range(1, 50)); i++) begin
                bus.clr_count = ($urandom_range(0, 15) == 0);
                cyc();
            end
        end
        bus.clr_count = 1'b0;
        wait_c(1'b0, 100, n);

        // Asynchronous reset in the middle of HOLD.
        bus.sensor_raw = 1'b1;
        wait_c(1'b1, 40, n);
        cnt_before = int'(bus.car_count);
        check("pre_hold_count", 32'(cnt_before), 32'(m_count));
        bus.sensor_raw = 1'b0;
        n = 0;
        while (m_mode != M_HOLD && n < 60) begin
            cyc();
            n++;
        end
        run(2);
        check("in_hold_c", 32'(bus.c), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_c", 32'(bus.c), 32'd0);
        check("async_rst_fault", 32'(bus.fault), 32'd0);
        check("async_rst_count", 32'(bus.car_count), 32'd0);
        run(3);
        rst_n = 1'b1;
        run(20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
